// File: rtl/urp_pcie_rx_dll_acknak.sv
// PCIe RX data link layer: LCRC/sequence check of incoming TLPs, in-order forwarding
// through a 1-entry output register, and coalesced ACK/NAK DLLP generation.
module urp_pcie_rx_dll_acknak #(
    parameter int TLP_WIDTH    = 224,
    parameter int SEQ_WIDTH    = 12,
    parameter int ACK_COALESCE = 4,
    parameter int ACK_LATENCY  = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [SEQ_WIDTH+TLP_WIDTH+31:0]   tlp_data_i,
    input  logic                              tlp_data_valid_i,
    output logic                              tlp_data_ready_o,
    output logic [TLP_WIDTH-1:0]              tlp_data_o,
    output logic                              tlp_data_valid_o,
    input  logic                              tlp_data_ready_i,
    output logic [31:0]                       dllp_o,
    output logic                              dllp_valid_o,
    input  logic                              dllp_read_i,
    output logic                              lcrc_err_o,
    output logic                              seq_err_o
);

    localparam int CRC_IN_W = SEQ_WIDTH + TLP_WIDTH;
    localparam int CNT_W    = $clog2(ACK_COALESCE + 1);
    localparam int TMR_W    = $clog2(ACK_LATENCY + 1);
    localparam logic [31:0]          CRC_POLY = 32'h04C1_1DB7;
    localparam logic [SEQ_WIDTH-1:0] SEQ_HALF = SEQ_WIDTH'(1) << (SEQ_WIDTH - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(ACK_COALESCE);
    localparam logic [TMR_W-1:0]     TMR_MAX  = TMR_W'(ACK_LATENCY - 1);

    // CRC-32, all-ones preset, MSB-first over {seq, tlp}, final complement
    function automatic logic [31:0] f_crc32(input logic [CRC_IN_W-1:0] d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = CRC_IN_W - 1; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return ~c;
    endfunction

    logic [SEQ_WIDTH-1:0] r_next_seq;
    logic [TLP_WIDTH-1:0] r_tlp_data;
    logic                 r_tlp_vld;
    logic [31:0]          r_dllp;
    logic                 r_dllp_vld;
    logic                 r_lcrc_err;
    logic                 r_seq_err;
    logic                 r_ack_pend;
    logic                 r_ack_force;
    logic                 r_nak_sched;
    logic                 r_nak_sent;
    logic [CNT_W-1:0]     r_count;
    logic [TMR_W-1:0]     r_timer;

    logic [SEQ_WIDTH-1:0] w_seq;
    logic [TLP_WIDTH-1:0] w_tlp;
    logic [31:0]          w_lcrc;
    logic                 w_crc_ok;
    logic                 w_accept;
    logic [SEQ_WIDTH-1:0] w_diff;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_in_order;
    logic                 w_dup;
    logic                 w_ahead;
    logic [SEQ_WIDTH-1:0] w_seq_nxt;
    logic [SEQ_WIDTH-1:0] w_ack_seq;
    logic                 w_can_issue;
    logic                 w_nak_req;
    logic                 w_ack_req;
    logic                 w_issue_nak;
    logic                 w_issue_ack;

    assign w_seq  = tlp_data_i[CRC_IN_W+31 -: SEQ_WIDTH];
    assign w_tlp  = tlp_data_i[TLP_WIDTH+31:32];
    assign w_lcrc = tlp_data_i[31:0];

    assign w_crc_ok         = (f_crc32(tlp_data_i[CRC_IN_W+31:32]) == w_lcrc);
    assign tlp_data_ready_o = !r_tlp_vld | tlp_data_ready_i;
    assign w_accept         = tlp_data_valid_i & tlp_data_ready_o;

    // D = NEXT_RCV_SEQ - seq: 0 in order, 1..half duplicate, otherwise a TLP was lost
    assign w_diff     = r_next_seq - w_seq;
    assign w_good     = w_accept & w_crc_ok;
    assign w_bad      = w_accept & !w_crc_ok;
    assign w_in_order = w_good & (w_diff == '0);
    assign w_dup      = w_good & (w_diff != '0) & (w_diff <= SEQ_HALF);
    assign w_ahead    = w_good & (w_diff > SEQ_HALF);

    assign w_seq_nxt = w_in_order ? (r_next_seq + SEQ_WIDTH'(1)) : r_next_seq;
    assign w_ack_seq = w_seq_nxt - SEQ_WIDTH'(1);

    assign w_can_issue = !r_dllp_vld | dllp_read_i;
    assign w_nak_req   = r_nak_sched & !r_nak_sent;
    assign w_ack_req   = r_ack_force |
                         (r_ack_pend & ((r_count >= CNT_MAX) | (r_timer >= TMR_MAX)));
    assign w_issue_nak = w_can_issue & w_nak_req;
    assign w_issue_ack = w_can_issue & !w_nak_req & w_ack_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_seq <= '0;
            r_lcrc_err <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_next_seq <= w_seq_nxt;
            r_lcrc_err <= w_bad;
            r_seq_err  <= w_ahead;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tlp_data <= '0;
            r_tlp_vld  <= 1'b0;
        end else if (w_in_order) begin
            r_tlp_data <= w_tlp;
            r_tlp_vld  <= 1'b1;
        end else if (tlp_data_ready_i) begin
            r_tlp_vld  <= 1'b0;
        end
    end

    // An issued ACK covers every TLP accepted up to and including this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_pend  <= 1'b0;
            r_ack_force <= 1'b0;
            r_count     <= '0;
            r_timer     <= '0;
        end else if (w_issue_ack) begin
            r_ack_pend  <= 1'b0;
            r_ack_force <= 1'b0;
            r_count     <= '0;
            r_timer     <= '0;
        end else begin
            if (w_in_order) r_ack_pend <= 1'b1;
            if (w_dup) r_ack_force <= 1'b1;
            if (w_in_order && (r_count < CNT_MAX)) r_count <= r_count + CNT_W'(1);
            if (r_ack_pend && (r_timer < TMR_MAX)) r_timer <= r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nak_sched <= 1'b0;
            r_nak_sent  <= 1'b0;
        end else if (w_in_order) begin
            r_nak_sched <= 1'b0;
            r_nak_sent  <= 1'b0;
        end else begin
            if (w_bad || w_ahead) r_nak_sched <= 1'b1;
            if (w_issue_nak) r_nak_sent <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dllp     <= '0;
            r_dllp_vld <= 1'b0;
        end else if (w_issue_nak) begin
            r_dllp     <= {4'h1, 28'(w_ack_seq)};
            r_dllp_vld <= 1'b1;
        end else if (w_issue_ack) begin
            r_dllp     <= {4'h0, 28'(w_ack_seq)};
            r_dllp_vld <= 1'b1;
        end else if (dllp_read_i) begin
            r_dllp_vld <= 1'b0;
        end
    end

    assign tlp_data_o       = r_tlp_data;
    assign tlp_data_valid_o = r_tlp_vld;
    assign dllp_o           = r_dllp;
    assign dllp_valid_o     = r_dllp_vld;
    assign lcrc_err_o       = r_lcrc_err;
    assign seq_err_o        = r_seq_err;

endmodule

// File: tb/tb_urp_pcie_rx_dll_acknak.sv
// Directed bench for urp_pcie_rx_dll_acknak: per-cycle vector table plus hand-written
// sequences for ACK latency, reset mid-transfer and sequence wrap-around.
module tb_urp_pcie_rx_dll_acknak;

    localparam int TW = 224;
    localparam int SW = 12;
    localparam int IW = SW + TW + 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] tlp_data_i;
    logic          tlp_data_valid_i;
    logic          tlp_data_ready_o;
    logic [TW-1:0] tlp_data_o;
    logic          tlp_data_valid_o;
    logic          tlp_data_ready_i;
    logic [31:0]   dllp_o;
    logic          dllp_valid_o;
    logic          dllp_read_i;
    logic          lcrc_err_o;
    logic          seq_err_o;

    int n_vec = 0;
    int n_err = 0;

    urp_pcie_rx_dll_acknak #(
        .TLP_WIDTH(TW), .SEQ_WIDTH(SW), .ACK_COALESCE(4), .ACK_LATENCY(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tlp_data_i(tlp_data_i), .tlp_data_valid_i(tlp_data_valid_i),
        .tlp_data_ready_o(tlp_data_ready_o),
        .tlp_data_o(tlp_data_o), .tlp_data_valid_o(tlp_data_valid_o),
        .tlp_data_ready_i(tlp_data_ready_i),
        .dllp_o(dllp_o), .dllp_valid_o(dllp_valid_o), .dllp_read_i(dllp_read_i),
        .lcrc_err_o(lcrc_err_o), .seq_err_o(seq_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v;
        logic [11:0] seq;
        bit          bad;
        bit          rdy;
        bit          rd;
        bit          e_tv;
        logic [11:0] e_tseq;
        bit          e_dv;
        logic [31:0] e_dllp;
        bit          e_le;
        bit          e_se;
        bit          e_ro;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [TW-1:0] mk_tlp(input logic [11:0] s);
        logic [TW-1:0] t;
        for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = {4'(i), 16'hC0DE, s};
        return t;
    endfunction

    function automatic logic [31:0] crc_ref(input logic [SW+TW-1:0] d);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = SW + TW - 1; i >= 0; i--) begin
            c = c ^ {d[i], 31'b0};
            c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return ~c;
    endfunction

    function automatic logic [IW-1:0] mk_in(input logic [11:0] s, input bit bad);
        logic [SW+TW-1:0] body;
        body = {s, mk_tlp(s)};
        return {body, crc_ref(body) ^ {31'b0, bad}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit v, input logic [11:0] seq, input bit bad,
                       input bit rdy, input bit rd, input bit e_tv, input logic [11:0] e_tseq,
                       input bit e_dv, input logic [31:0] e_dllp, input bit e_le,
                       input bit e_se, input bit e_ro);
        vec_t t;
        t.rst = rst; t.v = v; t.seq = seq; t.bad = bad; t.rdy = rdy; t.rd = rd;
        t.e_tv = e_tv; t.e_tseq = e_tseq; t.e_dv = e_dv; t.e_dllp = e_dllp;
        t.e_le = e_le; t.e_se = e_se; t.e_ro = e_ro;
        tbl.push_back(t);
    endtask

    task automatic idle_inputs();
        tlp_data_valid_i = 1'b0;
        tlp_data_i       = '0;
        tlp_data_ready_i = 1'b1;
        dllp_read_i      = 1'b0;
    endtask

    // Leaves the caller on a falling edge with reset released
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t t, input int idx);
        if (t.rst) do_reset();
        tlp_data_valid_i = t.v;
        tlp_data_i       = mk_in(t.seq, t.bad);
        tlp_data_ready_i = t.rdy;
        dllp_read_i      = t.rd;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.tlp_valid", idx), 256'(tlp_data_valid_o), 256'(t.e_tv));
        if (t.e_tv) chk($sformatf("v%0d.tlp_data", idx), 256'(tlp_data_o), 256'(mk_tlp(t.e_tseq)));
        chk($sformatf("v%0d.dllp_valid", idx), 256'(dllp_valid_o), 256'(t.e_dv));
        if (t.e_dv) chk($sformatf("v%0d.dllp", idx), 256'(dllp_o), 256'(t.e_dllp));
        chk($sformatf("v%0d.lcrc_err", idx), 256'(lcrc_err_o), 256'(t.e_le));
        chk($sformatf("v%0d.seq_err", idx), 256'(seq_err_o), 256'(t.e_se));
        chk($sformatf("v%0d.ready_o", idx), 256'(tlp_data_ready_o), 256'(t.e_ro));
        @(negedge clk);
    endtask

    int found;
    int werr;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("reset.tlp_valid", 256'(tlp_data_valid_o), 256'(0));
        chk("reset.tlp_data", 256'(tlp_data_o), 256'(0));
        chk("reset.dllp_valid", 256'(dllp_valid_o), 256'(0));
        chk("reset.dllp", 256'(dllp_o), 256'(0));
        chk("reset.errs", 256'({lcrc_err_o, seq_err_o}), 256'(0));
        @(negedge clk);

        // In-order stream seq 0..3, one coalesced ACK for seq 3
        add(1,1,0,0,1,0, 1,0,  0,32'h0,         0,0,1);
        add(0,1,1,0,1,0, 1,1,  0,32'h0,         0,0,1);
        add(0,1,2,0,1,0, 1,2,  0,32'h0,         0,0,1);
        add(0,1,3,0,1,0, 1,3,  0,32'h0,         0,0,1);
        add(0,0,0,0,1,0, 0,0,  1,32'h0000_0003, 0,0,1);
        add(0,0,0,0,1,0, 0,0,  1,32'h0000_0003, 0,0,1);
        add(0,0,0,0,1,1, 0,0,  0,32'h0,         0,0,1);
        // Duplicate forces an immediate ACK, no seq error
        add(1,1,0,0,1,0, 1,0,  0,32'h0,         0,0,1);
        add(0,1,0,0,1,0, 0,0,  0,32'h0,         0,0,1);
        add(0,0,0,0,1,0, 0,0,  1,32'h0000_0000, 0,0,1);
        add(0,0,0,0,1,1, 0,0,  0,32'h0,         0,0,1);
        add(0,0,0,0,1,0, 0,0,  0,32'h0,         0,0,1);
        // Lost TLP: single NAK, repeat blocked, in-order recovery clears the NAK state
        add(1,1,0,0,1,0, 1,0,  0,32'h0,         0,0,1);
        add(0,1,2,0,1,0, 0,0,  0,32'h0,         0,1,1);
        add(0,0,0,0,1,0, 0,0,  1,32'h1000_0000, 0,0,1);
        add(0,1,2,0,1,0, 0,0,  1,32'h1000_0000, 0,1,1);
        add(0,0,0,0,1,1, 0,0,  0,32'h0,         0,0,1);
        add(0,1,1,0,1,0, 1,1,  0,32'h0,         0,0,1);
        add(0,0,0,0,1,0, 0,0,  0,32'h0,         0,0,1);
        // Bad LCRC: NAK with all-ones sequence field; read while idle ignored
        add(1,1,0,1,1,0, 0,0,  0,32'h0,         1,0,1);
        add(0,0,0,0,1,0, 0,0,  1,32'h1000_0FFF, 0,0,1);
        add(0,0,0,0,1,1, 0,0,  0,32'h0,         0,0,1);
        add(0,0,0,0,1,1, 0,0,  0,32'h0,         0,0,1);
        // NAK held, then duplicate: ACK reloads back-to-back on the read
        add(1,1,0,0,1,0, 1,0,  0,32'h0,         0,0,1);
        add(0,1,2,0,1,0, 0,0,  0,32'h0,         0,1,1);
        add(0,0,0,0,1,0, 0,0,  1,32'h1000_0000, 0,0,1);
        add(0,1,0,0,1,0, 0,0,  1,32'h1000_0000, 0,0,1);
        add(0,0,0,0,1,1, 0,0,  1,32'h0000_0000, 0,0,1);
        add(0,0,0,0,1,1, 0,0,  0,32'h0,         0,0,1);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // ACK latency: lone TLP is acknowledged by the timer
        do_reset();
        tlp_data_valid_i = 1'b1;
        tlp_data_i       = mk_in(12'd0, 1'b0);
        @(posedge clk);
        #1;
        idle_inputs();
        found = -1;
        for (int k = 1; k <= 100 && found < 0; k++) begin
            @(posedge clk);
            #1;
            if (dllp_valid_o) found = k;
        end
        chk("t2.ack_latency", 256'(found), 256'(64));
        chk("t2.ack_value", 256'(dllp_o), 256'(32'h0000_0000));
        dllp_read_i = 1'b1;
        @(posedge clk);
        #1;
        dllp_read_i = 1'b0;
        chk("t2.ack_drop", 256'(dllp_valid_o), 256'(0));

        // Reset while a TLP and a DLLP are both held
        @(negedge clk);
        do_reset();
        tlp_data_valid_i = 1'b1;
        tlp_data_i       = mk_in(12'd0, 1'b1);
        @(negedge clk);
        tlp_data_i       = mk_in(12'd0, 1'b0);
        tlp_data_ready_i = 1'b0;
        @(negedge clk);
        tlp_data_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.pre_tlp_valid", 256'(tlp_data_valid_o), 256'(1));
        chk("rst_mid.pre_dllp", 256'({dllp_valid_o, dllp_o}), 256'({1'b1, 32'h1000_0000}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.tlp_valid", 256'(tlp_data_valid_o), 256'(0));
        chk("rst_mid.tlp_data", 256'(tlp_data_o), 256'(0));
        chk("rst_mid.dllp", 256'({dllp_valid_o, dllp_o}), 256'(0));
        @(negedge clk);

        // Advance NEXT_RCV_SEQ to 4095 with the ACK path drained continuously
        do_reset();
        dllp_read_i = 1'b1;
        werr = 0;
        for (int s = 0; s < 4095; s++) begin
            tlp_data_valid_i = 1'b1;
            tlp_data_i       = mk_in(12'(s), 1'b0);
            @(posedge clk);
            #1;
            if (lcrc_err_o || seq_err_o) werr++;
            @(negedge clk);
        end
        chk("t6.warm_data", 256'(tlp_data_o), 256'(mk_tlp(12'd4094)));
        chk("t6.warm_errs", 256'(werr), 256'(0));
        tlp_data_valid_i = 1'b0;
        repeat (80) @(negedge clk);
        dllp_read_i = 1'b0;
        @(posedge clk);
        #1;
        chk("t6.warm_drained", 256'(dllp_valid_o), 256'(0));
        @(negedge clk);

        // Wrap-around with a stalled transaction layer
        tbl.delete();
        add(0,1,12'hFFF,0,0,0, 1,12'hFFF, 0,32'h0, 0,0,0);
        add(0,1,12'h000,0,0,0, 1,12'hFFF, 0,32'h0, 0,0,0);
        add(0,1,12'h000,0,1,0, 1,12'h000, 0,32'h0, 0,0,1);
        add(0,0,12'h000,0,0,0, 1,12'h000, 0,32'h0, 0,0,0);
        add(0,0,12'h000,0,1,0, 0,12'h000, 0,32'h0, 0,0,1);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 100 + i);

        found = -1;
        for (int k = 1; k <= 100 && found < 0; k++) begin
            @(posedge clk);
            #1;
            if (dllp_valid_o) found = k;
        end
        chk("t6.ack_seen", 256'(found > 0), 256'(1));
        chk("t6.ack_value", 256'(dllp_o), 256'(32'h0000_0000));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t6.hold%0d", k), 256'({dllp_valid_o, dllp_o}), 256'({1'b1, 32'h0}));
        end
        dllp_read_i = 1'b1;
        @(posedge clk);
        #1;
        dllp_read_i = 1'b0;
        chk("t6.ack_drop", 256'(dllp_valid_o), 256'(0));
        chk("t6.tlp_idle", 256'(tlp_data_valid_o), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
